// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, defaults and address helpers for the instruction cache
package icache_pkg;

    localparam int DEFAULT_INDEX_BITS = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2
    } state_t;

    // Entry index: halfword-granular PC bits just above bit 0
    function automatic logic [31:0] icache_idx(input logic [31:0] pc, input int index_bits);
        return (pc >> 1) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    // Tag: every PC bit above the index
    function automatic logic [31:0] icache_tag(input logic [31:0] pc, input int index_bits);
        return pc >> (index_bits + 1);
    endfunction

endpackage

// File: rtl/icache_fetch_unit_if.sv
// rtl/icache_fetch_unit_if.sv - fetch-side request/response and adapter insfetch signals
interface icache_fetch_unit_if;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_ins;
    logic [31:0] resp_pc;
    logic        try_start_insfetch_task;
    logic [31:0] insfetch_addr;
    logic        insfetch_task_done;
    logic [31:0] insfetch_ins_full;

    // Cache side
    modport slave (
        input  req_valid, req_pc, insfetch_task_done, insfetch_ins_full,
        output req_ready, resp_valid, resp_ins, resp_pc, try_start_insfetch_task, insfetch_addr
    );

    // Fetch stage plus adapter side
    modport master (
        output req_valid, req_pc, insfetch_task_done, insfetch_ins_full,
        input  req_ready, resp_valid, resp_ins, resp_pc, try_start_insfetch_task, insfetch_addr
    );
endinterface

// File: rtl/icache_store.sv
// rtl/icache_store.sv - valid/tag/data storage with combinational read and one write port
module icache_store
    import icache_pkg::*;
#(
    parameter  int INDEX_BITS = DEFAULT_INDEX_BITS,
    localparam int TAG_BITS   = 31 - INDEX_BITS,
    localparam int ENTRIES    = 1 << INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data,
    input  logic                  inval
);

    logic [ENTRIES-1:0]  valid_r;
    logic [TAG_BITS-1:0] tag_r  [ENTRIES];
    logic [31:0]         data_r [ENTRIES];

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

    // Valid bits: invalidate beats a same-cycle fill so the filled entry stays invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else if (inval) begin
            valid_r <= '0;
        end else if (we) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; valid bits alone gate their use
    always_ff @(posedge clk) begin
        if (we) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_fetch_unit.sv
// rtl/icache_fetch_unit.sv - direct-mapped instruction cache FSM and handshakes
module icache_fetch_unit
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_pipline,
    input  logic                icache_inval,
    icache_fetch_unit_if.slave  bus
);

    localparam int TAG_BITS = 31 - INDEX_BITS;

    state_t                state_r, state_nxt;
    logic [31:0]           pc_r;
    logic                  resp_valid_r;
    logic [31:0]           resp_ins_r;
    logic [31:0]           resp_pc_r;

    logic                  accept, resp_set, fill_we, req_ready, try_start;
    logic [31:0]           resp_data;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;

    assign idx = INDEX_BITS'(icache_idx(pc_r, INDEX_BITS));
    assign tag = TAG_BITS'(icache_tag(pc_r, INDEX_BITS));
    assign hit = rd_valid && (rd_tag == tag);

    icache_store #(.INDEX_BITS(INDEX_BITS)) u_store (
        .clk     (clk_in),
        .rst     (rst_in),
        .rd_idx  (idx),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (fill_we && rdy_in),
        .wr_idx  (idx),
        .wr_tag  (tag),
        .wr_data (bus.insfetch_ins_full),
        .inval   (icache_inval && rdy_in)
    );

    // State register; rdy_in low freezes it
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else if (rdy_in) begin
            state_r <= state_nxt;
        end
    end

    // Next state, handshake outputs and datapath strobes; flush overrides everything
    always_comb begin
        state_nxt = state_r;
        accept    = 1'b0;
        resp_set  = 1'b0;
        fill_we   = 1'b0;
        req_ready = 1'b0;
        try_start = 1'b0;
        resp_data = rd_data;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp_set  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = MISS;
                end
            end
            MISS: begin
                try_start = 1'b1;
                resp_data = bus.insfetch_ins_full;
                if (bus.insfetch_task_done) begin
                    fill_we   = 1'b1;
                    resp_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_pipline) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            resp_set  = 1'b0;
            fill_we   = 1'b0;
        end
    end

    // Request PC latch and registered response; resp_valid self-clears each enabled edge
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_r         <= '0;
            resp_valid_r <= 1'b0;
            resp_ins_r   <= '0;
            resp_pc_r    <= '0;
        end else if (rdy_in) begin
            resp_valid_r <= resp_set;
            if (accept) begin
                pc_r <= {bus.req_pc[31:1], 1'b0};
            end
            if (resp_set) begin
                resp_ins_r <= resp_data;
                resp_pc_r  <= pc_r;
            end
        end
    end

    assign bus.req_ready               = req_ready;
    assign bus.resp_valid              = resp_valid_r;
    assign bus.resp_ins                = resp_ins_r;
    assign bus.resp_pc                 = resp_pc_r;
    assign bus.try_start_insfetch_task = try_start;
    assign bus.insfetch_addr           = pc_r;

endmodule

// File: tb/tb_icache_fetch_unit.sv
// tb/tb_icache_fetch_unit.sv - directed self-checking bench for icache_fetch_unit
module tb_icache_fetch_unit;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush_pipline;
    logic icache_inval;
    int   checks = 0;
    int   errors = 0;

    icache_fetch_unit_if bus ();

    icache_fetch_unit dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_pipline(flush_pipline),
        .icache_inval (icache_inval),
        .bus          (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_req(input logic [31:0] pc);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic give_done(input logic [31:0] d, input logic inv);
        bus.insfetch_task_done = 1'b1;
        bus.insfetch_ins_full  = d;
        icache_inval           = inv;
        tick(1);
        bus.insfetch_task_done = 1'b0;
        icache_inval           = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0h want 0", bus.resp_valid); end
        checks++; if (bus.try_start_insfetch_task !== 1'b0) begin errors++; $display("FAIL reset_try_start got %0h want 0", bus.try_start_insfetch_task); end
        checks++; if (bus.resp_ins !== 32'h0) begin errors++; $display("FAIL reset_resp_ins got %h want 0", bus.resp_ins); end
        checks++; if (bus.resp_pc !== 32'h0) begin errors++; $display("FAIL reset_resp_pc got %h want 0", bus.resp_pc); end
        checks++; if (bus.insfetch_addr !== 32'h0) begin errors++; $display("FAIL reset_insfetch_addr got %h want 0", bus.insfetch_addr); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0h want 1", bus.req_ready); end
        rst_in = 1'b0;
        tick(1);
    endtask

    task automatic test_cold_miss();
        send_req(32'h0000_1000);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL cold_lookup_ready got %0h want 0", bus.req_ready); end
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1) begin errors++; $display("FAIL cold_try_start got %0h want 1", bus.try_start_insfetch_task); end
        checks++; if (bus.insfetch_addr !== 32'h0000_1000) begin errors++; $display("FAIL cold_addr got %h want 00001000", bus.insfetch_addr); end
        tick(2);
        checks++; if (bus.try_start_insfetch_task !== 1'b1 || bus.insfetch_addr !== 32'h0000_1000) begin errors++; $display("FAIL cold_hold got %0h/%h want 1/00001000", bus.try_start_insfetch_task, bus.insfetch_addr); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL cold_early_resp got %0h want 0", bus.resp_valid); end
        give_done(32'h0000_0513, 1'b0);
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL cold_resp_valid got %0h want 1", bus.resp_valid); end
        checks++; if (bus.resp_ins !== 32'h0000_0513) begin errors++; $display("FAIL cold_resp_ins got %h want 00000513", bus.resp_ins); end
        checks++; if (bus.resp_pc !== 32'h0000_1000) begin errors++; $display("FAIL cold_resp_pc got %h want 00001000", bus.resp_pc); end
        checks++; if (bus.try_start_insfetch_task !== 1'b0) begin errors++; $display("FAIL cold_try_drop got %0h want 0", bus.try_start_insfetch_task); end
        tick(1);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL cold_resp_pulse got %0h want 0", bus.resp_valid); end
    endtask

    task automatic test_hit();
        send_req(32'h0000_1000);
        checks++; if (bus.resp_valid !== 1'b0 || bus.try_start_insfetch_task !== 1'b0) begin errors++; $display("FAIL hit_cycle1 got %0h/%0h want 0/0", bus.resp_valid, bus.try_start_insfetch_task); end
        tick(1);
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL hit_resp_valid got %0h want 1", bus.resp_valid); end
        checks++; if (bus.resp_ins !== 32'h0000_0513 || bus.resp_pc !== 32'h0000_1000) begin errors++; $display("FAIL hit_resp got %h/%h want 00000513/00001000", bus.resp_ins, bus.resp_pc); end
        checks++; if (bus.try_start_insfetch_task !== 1'b0) begin errors++; $display("FAIL hit_try_start got %0h want 0", bus.try_start_insfetch_task); end
        tick(1);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL hit_pulse got %0h want 0", bus.resp_valid); end
    endtask

    task automatic test_alias();
        send_req(32'h0000_1003);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1 || bus.insfetch_addr !== 32'h0000_1002) begin errors++; $display("FAIL alias_miss1 got %0h/%h want 1/00001002", bus.try_start_insfetch_task, bus.insfetch_addr); end
        give_done(32'h0000_4501, 1'b0);
        checks++; if (bus.resp_ins !== 32'h0000_4501 || bus.resp_pc !== 32'h0000_1002) begin errors++; $display("FAIL alias_resp1 got %h/%h want 00004501/00001002", bus.resp_ins, bus.resp_pc); end
        send_req(32'h0000_1082);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1 || bus.insfetch_addr !== 32'h0000_1082) begin errors++; $display("FAIL alias_miss2 got %0h/%h want 1/00001082", bus.try_start_insfetch_task, bus.insfetch_addr); end
        give_done(32'hdead_beef, 1'b0);
        send_req(32'h0000_1002);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL alias_miss3 got %0h/%0h want 1/0", bus.try_start_insfetch_task, bus.resp_valid); end
        give_done(32'h0000_4501, 1'b0);
        send_req(32'h0000_1082);
        tick(1);
        checks++; if (bus.resp_valid !== 1'b0 || bus.try_start_insfetch_task !== 1'b1) begin errors++; $display("FAIL alias_evicted got %0h/%0h want 0/1", bus.resp_valid, bus.try_start_insfetch_task); end
        give_done(32'hdead_beef, 1'b0);
    endtask

    task automatic test_flush();
        send_req(32'h0000_2000);
        tick(2);
        flush_pipline = 1'b1;
        tick(1);
        flush_pipline = 1'b0;
        checks++; if (bus.try_start_insfetch_task !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got %0h/%0h want 0/1", bus.try_start_insfetch_task, bus.req_ready); end
        tick(2);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL flush_no_resp got %0h want 0", bus.resp_valid); end
        send_req(32'h0000_2000);
        tick(1);
        flush_pipline          = 1'b1;
        bus.insfetch_task_done = 1'b1;
        bus.insfetch_ins_full  = 32'h1111_1111;
        tick(1);
        flush_pipline          = 1'b0;
        bus.insfetch_task_done = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0 || bus.try_start_insfetch_task !== 1'b0) begin errors++; $display("FAIL flush_done got %0h/%0h want 0/0", bus.resp_valid, bus.try_start_insfetch_task); end
        send_req(32'h0000_2000);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1) begin errors++; $display("FAIL flush_refetch got %0h want 1", bus.try_start_insfetch_task); end
        give_done(32'h2222_2222, 1'b0);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_ins !== 32'h2222_2222) begin errors++; $display("FAIL flush_refill got %0h/%h want 1/22222222", bus.resp_valid, bus.resp_ins); end
    endtask

    task automatic test_inval();
        send_req(32'h0000_3000);
        tick(1);
        give_done(32'h0000_3333, 1'b0);
        send_req(32'h0000_3000);
        tick(1);
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL inval_prehit got %0h want 1", bus.resp_valid); end
        icache_inval = 1'b1;
        tick(1);
        icache_inval = 1'b0;
        send_req(32'h0000_3000);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1) begin errors++; $display("FAIL inval_miss got %0h want 1", bus.try_start_insfetch_task); end
        give_done(32'h0000_3333, 1'b1);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_ins !== 32'h0000_3333) begin errors++; $display("FAIL inval_fill_resp got %0h/%h want 1/00003333", bus.resp_valid, bus.resp_ins); end
        send_req(32'h0000_3000);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1) begin errors++; $display("FAIL inval_fill_dropped got %0h want 1", bus.try_start_insfetch_task); end
        give_done(32'h0000_3333, 1'b0);
        send_req(32'h0000_3000);
        icache_inval = 1'b1;
        tick(1);
        icache_inval = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL inval_lookup_prebits got %0h want 1", bus.resp_valid); end
        send_req(32'h0000_3000);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1) begin errors++; $display("FAIL inval_lookup_after got %0h want 1", bus.try_start_insfetch_task); end
        give_done(32'h0000_3333, 1'b0);
    endtask

    task automatic test_rdy_freeze();
        send_req(32'h0000_3000);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.try_start_insfetch_task !== 1'b0) begin errors++; $display("FAIL rdy_frozen cyc %0d got %0h/%0h/%0h want 0/0/0", i, bus.resp_valid, bus.req_ready, bus.try_start_insfetch_task); end
        end
        rdy_in = 1'b1;
        tick(1);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_ins !== 32'h0000_3333) begin errors++; $display("FAIL rdy_resume got %0h/%h want 1/00003333", bus.resp_valid, bus.resp_ins); end
        rdy_in = 1'b0;
        tick(2);
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL rdy_hold_pulse got %0h want 1", bus.resp_valid); end
        rdy_in = 1'b1;
        tick(1);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rdy_pulse_clear got %0h want 0", bus.resp_valid); end
    endtask

    task automatic test_async_reset();
        send_req(32'h0000_4000);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1) begin errors++; $display("FAIL areset_pre got %0h want 1", bus.try_start_insfetch_task); end
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (bus.try_start_insfetch_task !== 1'b0 || bus.insfetch_addr !== 32'h0) begin errors++; $display("FAIL areset_now got %0h/%h want 0/0", bus.try_start_insfetch_task, bus.insfetch_addr); end
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL areset_idle got %0h/%0h want 1/0", bus.req_ready, bus.resp_valid); end
        rst_in = 1'b0;
        tick(1);
        send_req(32'h0000_3000);
        tick(1);
        checks++; if (bus.try_start_insfetch_task !== 1'b1) begin errors++; $display("FAIL areset_valid_clear got %0h want 1", bus.try_start_insfetch_task); end
        give_done(32'h0000_3333, 1'b0);
    endtask

    initial begin
        rst_in                 = 1'b1;
        rdy_in                 = 1'b1;
        flush_pipline          = 1'b0;
        icache_inval           = 1'b0;
        bus.req_valid          = 1'b0;
        bus.req_pc             = 32'h0;
        bus.insfetch_task_done = 1'b0;
        bus.insfetch_ins_full  = 32'h0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_alias();
        test_flush();
        test_inval();
        test_rdy_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
